// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - state, opcode and ALU constants for the multi-cycle RV32I-subset core
package multicycle_pkg;

  localparam logic [2:0] FETCH     = 3'd0;
  localparam logic [2:0] DECODE    = 3'd1;
  localparam logic [2:0] EXECUTE   = 3'd2;
  localparam logic [2:0] MEMORY    = 3'd3;
  localparam logic [2:0] WRITEBACK = 3'd4;
  localparam logic [2:0] HALT      = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL
  } alu_op_e;

  typedef enum logic [2:0] {
    K_NONE, K_ALU_R, K_ALU_I, K_LOAD, K_STORE, K_BRANCH
  } kind_e;

  // 32-bit sign-extended immediate for the I, S and B formats
  function automatic logic [31:0] imm_of(input logic [31:0] ir);
    case (ir[6:0])
      OP_STORE:  imm_of = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH: imm_of = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      default:   imm_of = {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - combinational XLEN-wide ALU with zero flag
module multicycle_alu
  import multicycle_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLL: result = a << b[4:0];
      ALU_SRL: result = a >> b[4:0];
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// rtl/multicycle_datapath.sv - FSM-driven multi-cycle RV32I-subset datapath with its own memories
module multicycle_datapath
  import multicycle_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int DMEM_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  output logic [XLEN-1:0]  pc_o,
  output logic [2:0]       state_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output logic             halted_o,
  output logic             error_o
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH];
  logic [XLEN-1:0] regs [32];

  logic [2:0]       state;
  logic [XLEN-1:0]  pc, a, b, imm, alu_out, mdr;
  logic [31:0]      ir;
  logic [CNT_W-1:0] cnt;
  logic             error;

  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  kind_e      kind;
  alu_op_e    alu_op;
  logic       is_stop;

  assign rd  = ir[11:7];
  assign f3  = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign f7  = ir[31:25];
  assign is_stop = (ir == 32'h0) || (ir == EBREAK);

  // IR stays stable from DECODE onward, so the decode is recomputed rather than latched
  always_comb begin
    kind   = K_NONE;
    alu_op = ALU_ADD;
    case (ir[6:0])
      OP_R: begin
        if (f7 == F7_BASE) begin
          kind = K_ALU_R;
          case (f3)
            F3_ADD:  alu_op = ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SRL:  alu_op = ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: kind   = K_NONE;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          kind   = K_ALU_R;
          alu_op = ALU_SUB;
        end
      end
      OP_IMM: begin
        kind = K_ALU_I;
        case (f3)
          F3_ADD:  alu_op = ALU_ADD;
          F3_OR:   alu_op = ALU_OR;
          F3_AND:  alu_op = ALU_AND;
          default: kind   = K_NONE;
        endcase
      end
      OP_LOAD:   if (f3 == F3_W) kind = K_LOAD;
      OP_STORE:  if (f3 == F3_W) kind = K_STORE;
      OP_BRANCH: begin
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          kind   = K_BRANCH;
          alu_op = ALU_SUB;
        end
      end
      default: kind = K_NONE;
    endcase
  end

  logic [XLEN-1:0] alu_b, alu_res;
  logic            alu_zero;

  assign alu_b = (kind == K_ALU_R || kind == K_BRANCH) ? b : imm;

  multicycle_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_op),
    .a      (a),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  logic branch_taken, fetch_fault, mem_fault, retire;

  assign branch_taken = (f3 == F3_BNE) ? !alu_zero : alu_zero;
  assign fetch_fault  = (pc >= XLEN'(IMEM_DEPTH * 4)) || (pc[1:0] != 2'b00);
  assign mem_fault    = (alu_out[1:0] != 2'b00) || (alu_out >= XLEN'(DMEM_DEPTH * 4));

  // gated by reset so an aborted instruction never shows a retire pulse
  assign retire = !reset && ((state == EXECUTE && kind == K_BRANCH) ||
                             (state == MEMORY && kind == K_STORE && !mem_fault) ||
                             (state == WRITEBACK));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc    <= '0;
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (fetch_fault) begin
            state <= HALT;
            error <= 1'b1;
          end else begin
            ir    <= imem[pc[IAW+1:2]][31:0];
            state <= DECODE;
          end
        end
        DECODE: begin
          a   <= (rs1 == 5'd0) ? '0 : regs[rs1];
          b   <= (rs2 == 5'd0) ? '0 : regs[rs2];
          imm <= XLEN'($signed(imm_of(ir)));
          if (is_stop) begin
            state <= HALT;
          end else if (kind == K_NONE) begin
            state <= HALT;
            error <= 1'b1;
          end else begin
            state <= EXECUTE;
          end
        end
        EXECUTE: begin
          alu_out <= alu_res;
          if (kind == K_BRANCH) begin
            pc    <= branch_taken ? pc + imm : pc + XLEN'(4);
            state <= FETCH;
          end else if (kind == K_LOAD || kind == K_STORE) begin
            state <= MEMORY;
          end else begin
            state <= WRITEBACK;
          end
        end
        MEMORY: begin
          if (mem_fault) begin
            state <= HALT;
            error <= 1'b1;
          end else if (kind == K_STORE) begin
            dmem[alu_out[DAW+1:2]] <= b;
            pc    <= pc + XLEN'(4);
            state <= FETCH;
          end else begin
            mdr   <= dmem[alu_out[DAW+1:2]];
            state <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          if (rd != 5'd0) regs[rd] <= (kind == K_LOAD) ? mdr : alu_out;
          pc    <= pc + XLEN'(4);
          state <= FETCH;
        end
        default: state <= HALT;
      endcase
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  end

  assign pc_o          = pc;
  assign state_o       = state;
  assign retire_o      = retire;
  assign retired_cnt_o = cnt;
  assign halted_o      = (state == HALT);
  assign error_o       = error;

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb/tb_multicycle_datapath.sv - directed programs checked against an instruction-level model
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_o;
  logic [2:0]  state_o;
  logic        retire_o;
  logic [15:0] retired_cnt_o;
  logic        halted_o;
  logic        error_o;

  always #5 clk = ~clk;

  multicycle_datapath u (
    .clk           (clk),
    .reset         (reset),
    .pc_o          (pc_o),
    .state_o       (state_o),
    .retire_o      (retire_o),
    .retired_cnt_o (retired_cnt_o),
    .halted_o      (halted_o),
    .error_o       (error_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog[$];
  logic [31:0] init_regs [32];
  logic [31:0] m_imem [32];
  logic [31:0] m_dmem [32];
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_ipc;
  int          last_retire_c;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_ins(input int imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    logic [31:0] v = imm;
    return {v[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_ins(input int imm, input logic [4:0] rs2, input logic [4:0] rs1);
    logic [31:0] v = imm;
    return {v[11:5], rs2, rs1, 3'b010, v[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_ins(input int imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], 7'b1100011};
  endfunction

  // One architectural step. kind: 0 retire, 1 clean halt, 2 fault halt.
  // delta: cycles from the previous retire to the retire pulse, or to halted_o rising.
  task automatic model_step(output int kind, output int delta);
    logic [31:0] ins, a, b, ii, is, ib, res, addr;
    logic        wr, br;
    m_ipc = m_pc;
    kind = 2; delta = 3; wr = 0; br = 0; res = 0;
    if (m_pc >= 32'd128 || m_pc[1:0] != 2'b00) begin
      delta = 2;
      return;
    end
    ins = m_imem[m_pc[6:2]];
    if (ins == 32'h0 || ins == 32'h0010_0073) begin
      kind = 1;
      return;
    end
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    case (ins[6:0])
      7'b0110011: begin
        kind = 0; delta = 4; wr = 1;
        case ({ins[31:25], ins[14:12]})
          {7'h00, 3'b000}: res = a + b;
          {7'h20, 3'b000}: res = a - b;
          {7'h00, 3'b111}: res = a & b;
          {7'h00, 3'b110}: res = a | b;
          {7'h00, 3'b100}: res = a ^ b;
          {7'h00, 3'b001}: res = a << b[4:0];
          {7'h00, 3'b101}: res = a >> b[4:0];
          default: begin kind = 2; delta = 3; end
        endcase
      end
      7'b0010011: begin
        kind = 0; delta = 4; wr = 1;
        case (ins[14:12])
          3'b000:  res = a + ii;
          3'b111:  res = a & ii;
          3'b110:  res = a | ii;
          default: begin kind = 2; delta = 3; end
        endcase
      end
      7'b0000011: if (ins[14:12] == 3'b010) begin
        addr = a + ii;
        if (addr[1:0] != 2'b00 || addr >= 32'd128) begin kind = 2; delta = 5; end
        else begin kind = 0; delta = 5; wr = 1; res = m_dmem[addr[6:2]]; end
      end
      7'b0100011: if (ins[14:12] == 3'b010) begin
        addr = a + is;
        if (addr[1:0] != 2'b00 || addr >= 32'd128) begin kind = 2; delta = 5; end
        else begin kind = 0; delta = 4; m_dmem[addr[6:2]] = b; end
      end
      7'b1100011: if (ins[14:12] == 3'b000 || ins[14:12] == 3'b001) begin
        kind = 0; delta = 3; br = 1;
        m_pc = (((a == b) ^ ins[12]) != 1'b0) ? m_pc + ib : m_pc + 32'd4;
      end
      default: ;
    endcase
    if (kind == 0) begin
      if (wr && ins[11:7] != 5'd0) m_regs[ins[11:7]] = res;
      if (!br) m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic clear_init();
    prog.delete();
    for (int i = 0; i < 32; i++) init_regs[i] = 32'h0;
  endtask

  task automatic load();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
      m_dmem[i] = 32'h0;
      m_regs[i] = (i == 0) ? 32'h0 : init_regs[i];
      u.imem[i] = m_imem[i];
      u.dmem[i] = m_dmem[i];
      u.regs[i] = m_regs[i];
    end
    m_pc = 32'h0;
  endtask

  task automatic run_prog(input int budget);
    int  c, last, kind, delta, nret, bad;
    bit  done, exp_ret, exp_halt;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset pc_o", pc_o, 0);
    check("reset state_o", state_o, 0);
    check("reset retire_o", retire_o, 0);
    check("reset retired_cnt_o", retired_cnt_o, 0);
    check("reset halted_o", halted_o, 0);
    check("reset error_o", error_o, 0);
    reset = 1'b0;
    c = 1; last = 0; nret = 0; done = 0;
    model_step(kind, delta);
    while (!done && c <= budget) begin
      #1;
      exp_ret  = (kind == 0) && (c - last == delta);
      exp_halt = (kind != 0) && (c - last >= delta);
      check($sformatf("retire_o cycle %0d", c), retire_o, exp_ret);
      check($sformatf("halted_o cycle %0d", c), halted_o, exp_halt);
      if (exp_ret) begin
        check("pc_o at retire", pc_o, m_ipc);
        check("retired_cnt_o at retire", retired_cnt_o, nret);
        nret++;
        last = c;
        last_retire_c = c;
        model_step(kind, delta);
      end else if (exp_halt) begin
        check("error_o at halt", error_o, kind == 2);
        check("pc_o at halt", pc_o, m_ipc);
        check("retired_cnt_o at halt", retired_cnt_o, nret);
        done = 1;
      end
      if (!done) begin
        @(negedge clk);
        c++;
      end
    end
    if (!done) check("halt within cycle budget", 0, 1);
    bad = -1;
    for (int i = 1; i < 32; i++) if (u.regs[i] !== m_regs[i] && bad < 0) bad = i;
    check("register file vs model (first bad index)", bad, -1);
    bad = -1;
    for (int i = 0; i < 32; i++) if (u.dmem[i] !== m_dmem[i] && bad < 0) bad = i;
    check("data memory vs model (first bad index)", bad, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // arithmetic chain ending on an all-zero word
    clear_init();
    prog = '{i_ins(5, 0, 3'b000, 1, 7'b0010011), i_ins(7, 0, 3'b000, 2, 7'b0010011),
             r_ins(7'h00, 2, 1, 3'b000, 3), 32'h0};
    load(); run_prog(200);
    check("p1 x3", u.regs[3], 32'd12);
    check("p1 cnt", retired_cnt_o, 3);
    check("p1 last retire cycle", last_retire_c, 12);
    check("p1 error_o", error_o, 0);

    // store then load back through memory
    clear_init(); init_regs[3] = 32'd12;
    prog = '{s_ins(8, 3, 0), i_ins(8, 0, 3'b010, 4, 7'b0000011), 32'h0};
    load(); run_prog(200);
    check("p2 dmem[2]", u.dmem[2], 32'd12);
    check("p2 x4", u.regs[4], 32'd12);
    check("p2 last retire cycle", last_retire_c, 9);

    // taken beq skips, untaken bne falls through, ebreak stops cleanly
    clear_init(); init_regs[1] = 3; init_regs[2] = 3; init_regs[5] = 77;
    prog = '{b_ins(8, 2, 1, 3'b000), i_ins(1, 0, 3'b000, 5, 7'b0010011),
             b_ins(8, 2, 1, 3'b001), i_ins(4, 0, 3'b000, 6, 7'b0010011), 32'h0010_0073};
    load(); run_prog(200);
    check("p3 x5 unchanged", u.regs[5], 32'd77);
    check("p3 x6", u.regs[6], 32'd4);
    check("p3 last retire cycle", last_retire_c, 10);
    check("p3 error_o", error_o, 0);

    // ALU mix, shifts use only the low five bits of rs2, x0 is read-only
    clear_init(); init_regs[1] = 32'hF0F0_1234; init_regs[2] = 32'h24; init_regs[6] = 5;
    prog = '{r_ins(7'h20, 2, 1, 3'b000, 7), r_ins(7'h00, 2, 1, 3'b111, 8),
             r_ins(7'h00, 2, 1, 3'b110, 9), r_ins(7'h00, 2, 1, 3'b100, 10),
             r_ins(7'h00, 2, 1, 3'b001, 11), r_ins(7'h00, 2, 1, 3'b101, 12),
             i_ins(255, 1, 3'b111, 13, 7'b0010011), i_ins(-1, 1, 3'b110, 14, 7'b0010011),
             i_ins(-1, 1, 3'b000, 15, 7'b0010011), i_ins(9, 0, 3'b000, 0, 7'b0010011),
             r_ins(7'h00, 0, 0, 3'b000, 6), 32'h0};
    load(); run_prog(300);
    check("p4 sub x7", u.regs[7], 32'hF0F0_1210);
    check("p4 sll x11", u.regs[11], 32'h0F01_2340);
    check("p4 srl x12", u.regs[12], 32'h0F0F_0123);
    check("p4 andi x13", u.regs[13], 32'h34);
    check("p4 addi x15", u.regs[15], 32'hF0F0_1233);
    check("p4 x6 from x0", u.regs[6], 32'h0);

    // misaligned load
    clear_init(); init_regs[1] = 55;
    prog = '{i_ins(2, 0, 3'b010, 1, 7'b0000011)};
    load(); run_prog(100);
    check("p5 error_o", error_o, 1);
    check("p5 halted_o", halted_o, 1);
    check("p5 pc_o", pc_o, 0);
    check("p5 x1 unchanged", u.regs[1], 32'd55);

    // unsupported opcode after one good instruction
    clear_init();
    prog = '{i_ins(1, 0, 3'b000, 2, 7'b0010011), 32'h0000_007F};
    load(); run_prog(100);
    check("p6 error_o", error_o, 1);
    check("p6 pc_o", pc_o, 4);

    // branch to a misaligned target, then a store out of range
    clear_init();
    prog = '{b_ins(2, 0, 0, 3'b000)};
    load(); run_prog(100);
    check("p7 error_o", error_o, 1);
    check("p7 pc_o", pc_o, 2);
    clear_init(); init_regs[1] = 9;
    prog = '{s_ins(128, 1, 0)};
    load(); run_prog(100);
    check("p8 error_o", error_o, 1);

    // reset while sw sits in MEMORY aborts it without a commit
    clear_init(); init_regs[3] = 99;
    prog = '{s_ins(8, 3, 0), 32'h0};
    load();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort state_o is MEMORY", state_o, 3);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("abort dmem[2]", u.dmem[2], 32'h0);
    check("abort pc_o", pc_o, 0);
    check("abort retired_cnt_o", retired_cnt_o, 0);
    check("abort state_o", state_o, 0);
    load(); run_prog(100);
    check("rerun dmem[2]", u.dmem[2], 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
